// File: rtl/load_store_unit.sv
// Data-memory initiator: one request at a time, response after 3 (load) / 2 (store) cycles, held until resp_ready.
// Optional LSU_MISALIGN_TRAP_EN: misaligned requests skip memory and respond in 1 cycle with resp_misaligned set.
module load_store_unit #(
  parameter int XLEN = 64
) (
  input  logic            clock,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_is_store,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_misaligned,
  output logic            mem_read_en,
  output logic            mem_write_en,
  output logic [3:0]      mem_storetype,
  output logic [XLEN-1:0] mem_address,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam logic [3:0] STORE_BYTE       = 4'd1;
  localparam logic [3:0] STORE_HALFWORD   = 4'd2;
  localparam logic [3:0] STORE_WORD       = 4'd3;
  localparam logic [3:0] STORE_DOUBLEWORD = 4'd4;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_LD,
    CAPTURE,
    ISSUE_ST,
    RESP
  } state_t;

  state_t          state, state_nxt;
  logic [1:0]      lat_size;
  logic            lat_unsigned;
  logic            accept;
  logic            req_misaligned;
  logic            req_ready_nxt;
  logic            resp_valid_nxt;
  logic            resp_mis_nxt;
  logic            rd_en_nxt;
  logic            wr_en_nxt;
  logic [3:0]      storetype_nxt;
  logic [XLEN-1:0] rdata_nxt;
  logic [XLEN-1:0] addr_nxt;
  logic [XLEN-1:0] wdata_nxt;

  function automatic logic [3:0] store_code(input logic [1:0] size);
    logic [3:0] code;
    case (size)
      2'd0:    code = STORE_BYTE;
      2'd1:    code = STORE_HALFWORD;
      2'd2:    code = STORE_WORD;
      default: code = STORE_DOUBLEWORD;
    endcase
    return code;
  endfunction

  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] raw,
                                             input logic [1:0]      size,
                                             input logic            uns);
    logic [XLEN-1:0] v;
    case (size)
      2'd0:    v = {{(XLEN-8){~uns & raw[7]}}, raw[7:0]};
      2'd1:    v = {{(XLEN-16){~uns & raw[15]}}, raw[15:0]};
      2'd2:    v = {{(XLEN-32){~uns & raw[31]}}, raw[31:0]};
      default: v = raw;
    endcase
    return v;
  endfunction

  always_comb begin
    case (req_size)
      2'd1:    req_misaligned = req_addr[0];
      2'd2:    req_misaligned = |req_addr[1:0];
      2'd3:    req_misaligned = |req_addr[2:0];
      default: req_misaligned = 1'b0;
    endcase
  end

  // Next-cycle values of every output; the flops below make all outputs registered.
  always_comb begin
    state_nxt      = state;
    accept         = 1'b0;
    req_ready_nxt  = 1'b0;
    resp_valid_nxt = 1'b0;
    resp_mis_nxt   = resp_misaligned;
    rdata_nxt      = resp_rdata;
    rd_en_nxt      = 1'b0;
    wr_en_nxt      = 1'b0;
    storetype_nxt  = 4'b0;
    addr_nxt       = '0;
    wdata_nxt      = '0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (TRAP_EN && req_misaligned) begin
            state_nxt      = RESP;
            resp_valid_nxt = 1'b1;
            rdata_nxt      = '0;
            resp_mis_nxt   = 1'b1;
          end else if (req_is_store) begin
            state_nxt     = ISSUE_ST;
            wr_en_nxt     = 1'b1;
            storetype_nxt = store_code(req_size);
            addr_nxt      = req_addr;
            wdata_nxt     = req_wdata;
          end else begin
            state_nxt = ISSUE_LD;
            rd_en_nxt = 1'b1;
            addr_nxt  = req_addr;
          end
        end else begin
          req_ready_nxt = 1'b1;
        end
      end
      ISSUE_LD: begin
        state_nxt = CAPTURE;
      end
      CAPTURE: begin
        state_nxt      = RESP;
        resp_valid_nxt = 1'b1;
        rdata_nxt      = extend(mem_rdata, lat_size, lat_unsigned);
        resp_mis_nxt   = 1'b0;
      end
      ISSUE_ST: begin
        state_nxt      = RESP;
        resp_valid_nxt = 1'b1;
        rdata_nxt      = '0;
        resp_mis_nxt   = 1'b0;
      end
      RESP: begin
        if (resp_ready) begin
          state_nxt     = IDLE;
          req_ready_nxt = 1'b1;
          rdata_nxt     = '0;
          resp_mis_nxt  = 1'b0;
        end else begin
          resp_valid_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt     = IDLE;
        req_ready_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      req_ready       <= 1'b1;
      resp_valid      <= 1'b0;
      resp_rdata      <= '0;
      resp_misaligned <= 1'b0;
      mem_read_en     <= 1'b0;
      mem_write_en    <= 1'b0;
      mem_storetype   <= 4'b0;
      mem_address     <= '0;
      mem_wdata       <= '0;
      lat_size        <= 2'b0;
      lat_unsigned    <= 1'b0;
    end else begin
      req_ready       <= req_ready_nxt;
      resp_valid      <= resp_valid_nxt;
      resp_rdata      <= rdata_nxt;
      resp_misaligned <= resp_mis_nxt;
      mem_read_en     <= rd_en_nxt;
      mem_write_en    <= wr_en_nxt;
      mem_storetype   <= storetype_nxt;
      mem_address     <= addr_nxt;
      mem_wdata       <= wdata_nxt;
      if (accept) begin
        lat_size     <= req_size;
        lat_unsigned <= req_unsigned;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-addressed registered-read memory plus a transaction-level reference memory.
module tb_load_store_unit;
  localparam int XLEN = 64;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam logic [3:0] ST_CODE [4] = '{4'd1, 4'd2, 4'd3, 4'd4};

  logic            clock = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic            req_is_store = 1'b0;
  logic [1:0]      req_size = 2'd0;
  logic            req_unsigned = 1'b0;
  logic [XLEN-1:0] req_addr = '0;
  logic [XLEN-1:0] req_wdata = '0;
  logic            resp_valid;
  logic            resp_ready = 1'b0;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_misaligned;
  logic            mem_read_en;
  logic            mem_write_en;
  logic [3:0]      mem_storetype;
  logic [XLEN-1:0] mem_address;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;

  int checks = 0;
  int passed = 0;

  always #5 clock = ~clock;

  load_store_unit #(.XLEN(XLEN)) dut (
    .clock(clock), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_storetype(mem_storetype),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Data memory: 256 bytes, little-endian, one-cycle registered read, writes decoded from storetype.
  logic [7:0]      bmem [256];
  logic            fill = 1'b1;
  int              rd_cnt = 0, wr_cnt = 0, both_cnt = 0, st_bad_cnt = 0;
  logic [XLEN-1:0] last_addr = '0, last_wd = '0;
  logic [3:0]      last_st = '0;

  function automatic int st_bytes(input logic [3:0] code);
    case (code)
      4'd1:    return 1;
      4'd2:    return 2;
      4'd3:    return 4;
      4'd4:    return 8;
      default: return 0;
    endcase
  endfunction

  always @(posedge clock) begin
    if (fill)
      for (int i = 0; i < 256; i++) bmem[i] <= 8'(i * 37 + 11);
    if (mem_read_en) begin
      rd_cnt    <= rd_cnt + 1;
      last_addr <= mem_address;
      for (int i = 0; i < 8; i++) mem_rdata[8*i +: 8] <= bmem[8'(mem_address[7:0] + 8'(i))];
    end
    if (mem_write_en) begin
      wr_cnt    <= wr_cnt + 1;
      last_addr <= mem_address;
      last_st   <= mem_storetype;
      last_wd   <= mem_wdata;
      for (int i = 0; i < 8; i++)
        if (i < st_bytes(mem_storetype)) bmem[8'(mem_address[7:0] + 8'(i))] <= mem_wdata[8*i +: 8];
    end
    if (mem_read_en && mem_write_en) both_cnt <= both_cnt + 1;
    if (!mem_write_en && mem_storetype != 4'd0) st_bad_cnt <= st_bad_cnt + 1;
  end

  // Reference model: what memory should hold and what a load should return.
  logic [7:0] ref_mem [256];

  function automatic logic [63:0] ref_load(input logic [63:0] a, input int sz, input bit uns);
    int n;
    logic [63:0] v;
    n = 1 << sz;
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[8'(a[7:0] + 8'(i))];
    if (!uns && n < 8 && v[8*n-1])
      for (int i = 8 * n; i < 64; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic ref_store(input logic [63:0] a, input int sz, input logic [63:0] wd);
    for (int i = 0; i < (1 << sz); i++) ref_mem[8'(a[7:0] + 8'(i))] = wd[8*i +: 8];
  endtask

  // Issues one request from a negedge, waits for the response, holds resp_ready low for 'hold' cycles.
  task automatic do_req(input bit st, input logic [1:0] sz, input bit uns, input logic [63:0] a,
                        input logic [63:0] wd, input int hold, output logic [63:0] rd, output bit mis,
                        output int lat, output int rdd, output int wrd);
    int rd0, wr0;
    bit stable;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    checks++; if (req_ready !== 1'b1) $display("FAIL req_ready_idle got %b want 1", req_ready); else passed++;
    req_valid = 1'b1; req_is_store = st; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    @(posedge clock); @(negedge clock);
    req_valid = 1'b0; req_is_store = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 16) begin
      @(posedge clock); @(negedge clock);
      lat++;
    end
    rd = resp_rdata;
    mis = resp_misaligned;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); @(negedge clock);
      if (resp_valid !== 1'b1 || resp_rdata !== rd || resp_misaligned !== mis || req_ready !== 1'b0) stable = 1'b0;
    end
    checks++; if (!stable) $display("FAIL resp_hold got unstable want stable (hold %0d)", hold); else passed++;
    resp_ready = 1'b1;
    @(posedge clock); @(negedge clock);
    resp_ready = 1'b0;
    checks++; if (resp_valid !== 1'b0) $display("FAIL resp_valid_drop got %b want 0", resp_valid); else passed++;
    checks++; if (req_ready !== 1'b1) $display("FAIL req_ready_return got %b want 1", req_ready); else passed++;
    rdd = rd_cnt - rd0;
    wrd = wr_cnt - wr0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fill = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    fill = 1'b0;
    checks++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready got %b want 1", req_ready); else passed++;
    checks++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid got %b want 0", resp_valid); else passed++;
    checks++; if ({mem_read_en, mem_write_en, mem_storetype} !== 6'd0)
      $display("FAIL rst_mem_ctrl got %b want 0", {mem_read_en, mem_write_en, mem_storetype}); else passed++;
    checks++; if ({mem_address, mem_wdata, resp_rdata, resp_misaligned} !== '0)
      $display("FAIL rst_data got %h/%h/%h/%b want 0", mem_address, mem_wdata, resp_rdata, resp_misaligned); else passed++;
    rst = 1'b0;
    @(negedge clock);
    checks++; if (req_ready !== 1'b1) $display("FAIL post_rst_ready got %b want 1", req_ready); else passed++;
  endtask

  task automatic test_double();
    logic [63:0] rd; bit mis; int lat, rdd, wrd;
    do_req(1'b1, 2'd3, 1'b0, 64'h20, 64'h1122334455667788, 0, rd, mis, lat, rdd, wrd);
    ref_store(64'h20, 3, 64'h1122334455667788);
    checks++; if (lat !== 2) $display("FAIL sd_latency got %0d want 2", lat); else passed++;
    checks++; if (wrd !== 1 || rdd !== 0) $display("FAIL sd_pulses got wr %0d rd %0d want 1/0", wrd, rdd); else passed++;
    checks++; if (last_st !== 4'd4) $display("FAIL sd_storetype got %0d want 4", last_st); else passed++;
    checks++; if (rd !== 64'h0) $display("FAIL sd_rdata got %h want 0", rd); else passed++;
    do_req(1'b0, 2'd3, 1'b0, 64'h20, 64'h0, 1, rd, mis, lat, rdd, wrd);
    checks++; if (lat !== 3) $display("FAIL ld_latency got %0d want 3", lat); else passed++;
    checks++; if (rd !== 64'h1122334455667788) $display("FAIL ld_rdata got %h want 1122334455667788", rd); else passed++;
    checks++; if (rdd !== 1 || wrd !== 0) $display("FAIL ld_pulses got rd %0d wr %0d want 1/0", rdd, wrd); else passed++;
    checks++; if (last_addr !== 64'h20) $display("FAIL ld_addr got %h want 20", last_addr); else passed++;
  endtask

  task automatic test_sizes();
    logic [1:0]  sz [4] = '{2'd0, 2'd0, 2'd1, 2'd2};
    bit          un [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [63:0] ad [4] = '{64'h20, 64'h20, 64'h26, 64'h20};
    logic [63:0] ex [4] = '{64'hFFFFFFFFFFFFFF88, 64'h88, 64'h1122, 64'h55667788};
    logic [63:0] rd; bit mis; int lat, rdd, wrd;
    for (int k = 0; k < 4; k++) begin
      do_req(1'b0, sz[k], un[k], ad[k], 64'h0, 0, rd, mis, lat, rdd, wrd);
      checks++; if (rd !== ex[k]) $display("FAIL size_load_%0d got %h want %h", k, rd, ex[k]); else passed++;
    end
  endtask

  task automatic test_word_store();
    logic [63:0] rd; bit mis; int lat, rdd, wrd;
    do_req(1'b1, 2'd3, 1'b0, 64'h30, 64'hAABBCCDDEEFF0011, 0, rd, mis, lat, rdd, wrd);
    ref_store(64'h30, 3, 64'hAABBCCDDEEFF0011);
    do_req(1'b1, 2'd2, 1'b0, 64'h30, 64'hDEADBEEF80000000, 0, rd, mis, lat, rdd, wrd);
    ref_store(64'h30, 2, 64'hDEADBEEF80000000);
    checks++; if (last_st !== 4'd3) $display("FAIL sw_storetype got %0d want 3", last_st); else passed++;
    checks++; if (last_wd !== 64'hDEADBEEF80000000) $display("FAIL sw_wdata got %h want deadbeef80000000", last_wd); else passed++;
    do_req(1'b0, 2'd2, 1'b0, 64'h30, 64'h0, 0, rd, mis, lat, rdd, wrd);
    checks++; if (rd !== 64'hFFFFFFFF80000000) $display("FAIL lw_signed got %h want ffffffff80000000", rd); else passed++;
    do_req(1'b0, 2'd2, 1'b1, 64'h30, 64'h0, 0, rd, mis, lat, rdd, wrd);
    checks++; if (rd !== 64'h80000000) $display("FAIL lwu got %h want 80000000", rd); else passed++;
    do_req(1'b0, 2'd3, 1'b0, 64'h30, 64'h0, 0, rd, mis, lat, rdd, wrd);
    checks++; if (rd !== 64'hAABBCCDD80000000) $display("FAIL sw_upper_kept got %h want aabbccdd80000000", rd); else passed++;
  endtask

  task automatic test_backpressure();
    logic [63:0] ex;
    int lat, rd0, wr0, seen;
    ex = ref_load(64'h20, 3, 0);
    req_valid = 1'b1; req_is_store = 1'b0; req_size = 2'd3; req_unsigned = 1'b0; req_addr = 64'h20;
    @(posedge clock); @(negedge clock);
    req_valid = 1'b0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 16) begin
      @(posedge clock); @(negedge clock);
      lat++;
    end
    checks++; if (lat !== 3) $display("FAIL bp_latency got %0d want 3", lat); else passed++;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    for (int i = 0; i < 4; i++) begin
      checks++; if (resp_valid !== 1'b1) $display("FAIL bp_valid_%0d got %b want 1", i, resp_valid); else passed++;
      checks++; if (resp_rdata !== ex) $display("FAIL bp_rdata_%0d got %h want %h", i, resp_rdata, ex); else passed++;
      checks++; if (req_ready !== 1'b0) $display("FAIL bp_ready_%0d got %b want 0", i, req_ready); else passed++;
      if (i == 1) begin
        req_valid = 1'b1; req_is_store = 1'b1; req_addr = 64'h40; req_wdata = 64'h0123456789ABCDEF;
      end else begin
        req_valid = 1'b0;
      end
      @(posedge clock); @(negedge clock);
    end
    req_valid = 1'b0;
    checks++; if (rd_cnt - rd0 !== 0 || wr_cnt - wr0 !== 0)
      $display("FAIL bp_mem_idle got rd %0d wr %0d want 0/0", rd_cnt - rd0, wr_cnt - wr0); else passed++;
    resp_ready = 1'b1;
    @(posedge clock); @(negedge clock);
    resp_ready = 1'b0;
    checks++; if (req_ready !== 1'b1) $display("FAIL bp_ready_after got %b want 1", req_ready); else passed++;
    seen = 0;
    repeat (4) begin
      @(posedge clock); @(negedge clock);
      if (resp_valid === 1'b1) seen++;
    end
    checks++; if (seen !== 0 || wr_cnt - wr0 !== 0)
      $display("FAIL bp_ignored_req got resp %0d wr %0d want 0/0", seen, wr_cnt - wr0); else passed++;
  endtask

  task automatic test_reset_mid();
    int rd0, seen;
    rd0 = rd_cnt;
    req_valid = 1'b1; req_is_store = 1'b0; req_size = 2'd3; req_addr = 64'h20;
    @(posedge clock); @(negedge clock);
    req_valid = 1'b0;
    @(posedge clock); @(negedge clock);
    rst = 1'b1;
    @(posedge clock); @(negedge clock);
    checks++; if (req_ready !== 1'b1) $display("FAIL midrst_ready got %b want 1", req_ready); else passed++;
    checks++; if ({resp_valid, mem_read_en, mem_write_en, mem_storetype} !== 7'd0)
      $display("FAIL midrst_ctrl got %b want 0", {resp_valid, mem_read_en, mem_write_en, mem_storetype}); else passed++;
    checks++; if ({resp_rdata, mem_address, mem_wdata} !== '0)
      $display("FAIL midrst_data got %h/%h want 0", resp_rdata, mem_address); else passed++;
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clock); @(negedge clock);
      if (resp_valid === 1'b1) seen++;
    end
    checks++; if (seen !== 0) $display("FAIL midrst_no_resp got %0d want 0", seen); else passed++;
    checks++; if (rd_cnt - rd0 !== 1) $display("FAIL midrst_read_issued got %0d want 1", rd_cnt - rd0); else passed++;
  endtask

  task automatic test_misaligned();
    logic [63:0] rd, exp_rd; bit mis; int lat, rdd, wrd;
    exp_rd = TRAP ? 64'h0 : ref_load(64'h21, 3, 0);
    do_req(1'b0, 2'd3, 1'b0, 64'h21, 64'h0, 0, rd, mis, lat, rdd, wrd);
    checks++; if (lat !== (TRAP ? 1 : 3)) $display("FAIL mis_ld_latency got %0d want %0d", lat, TRAP ? 1 : 3); else passed++;
    checks++; if (rd !== exp_rd) $display("FAIL mis_ld_rdata got %h want %h", rd, exp_rd); else passed++;
    checks++; if (mis !== TRAP) $display("FAIL mis_ld_flag got %b want %b", mis, TRAP); else passed++;
    checks++; if (rdd !== (TRAP ? 0 : 1)) $display("FAIL mis_ld_read got %0d want %0d", rdd, TRAP ? 0 : 1); else passed++;
  endtask

  task automatic test_random();
    logic [63:0] a, wd, rd, exp_rd;
    logic [2:0]  m;
    logic [1:0]  sz;
    bit st, uns, mis, exp_mis;
    int lat, rdd, wrd, exp_lat, hold;
    for (int n = 0; n < 60; n++) begin
      st = ($urandom_range(0, 9) < 4);
      sz = 2'($urandom_range(0, 3));
      uns = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom};
      wd = {$urandom, $urandom};
      hold = $urandom_range(0, 2);
      m = (sz == 2'd0) ? 3'd0 : (sz == 2'd1) ? 3'd1 : (sz == 2'd2) ? 3'd3 : 3'd7;
      if ($urandom_range(0, 3) != 0) a[2:0] = a[2:0] & ~m;
      exp_mis = TRAP && ((a[2:0] & m) != 3'd0);
      exp_rd = (st || exp_mis) ? 64'h0 : ref_load(a, sz, uns);
      exp_lat = exp_mis ? 1 : (st ? 2 : 3);
      do_req(st, sz, uns, a, wd, hold, rd, mis, lat, rdd, wrd);
      if (st && !exp_mis) ref_store(a, sz, wd);
      checks++; if (rd !== exp_rd) $display("FAIL rnd%0d_rdata got %h want %h", n, rd, exp_rd); else passed++;
      checks++; if (lat !== exp_lat) $display("FAIL rnd%0d_latency got %0d want %0d", n, lat, exp_lat); else passed++;
      checks++; if (mis !== exp_mis) $display("FAIL rnd%0d_misaligned got %b want %b", n, mis, exp_mis); else passed++;
      checks++; if (rdd !== int'(!st && !exp_mis) || wrd !== int'(st && !exp_mis))
        $display("FAIL rnd%0d_pulses got rd %0d wr %0d want %0d/%0d", n, rdd, wrd, !st && !exp_mis, st && !exp_mis); else passed++;
      if (!exp_mis) begin
        checks++; if (last_addr !== a) $display("FAIL rnd%0d_addr got %h want %h", n, last_addr, a); else passed++;
      end
      if (st && !exp_mis) begin
        checks++; if (last_st !== ST_CODE[sz]) $display("FAIL rnd%0d_storetype got %0d want %0d", n, last_st, ST_CODE[sz]); else passed++;
      end
    end
  endtask

  task automatic test_invariants();
    checks++; if (both_cnt !== 0) $display("FAIL rd_wr_overlap got %0d want 0", both_cnt); else passed++;
    checks++; if (st_bad_cnt !== 0) $display("FAIL storetype_idle got %0d want 0", st_bad_cnt); else passed++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 11);
    test_reset();
    test_double();
    test_sizes();
    test_word_store();
    test_backpressure();
    test_reset_mid();
    test_misaligned();
    test_random();
    test_invariants();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got timeout want finish (%0d/%0d so far)", passed, checks);
    $fatal(1, "watchdog");
  end

endmodule
